valid_packer: RTL

VALID_PACKER -- requirements
Module: valid_packer

---
 rtl/valid_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/valid_packer.sv
// valid_packer: packs N_PACK input beats (LSB first) into one word and queues words in a DEPTH-entry FIFO.
// Optional macro PACKER_FLUSH_EN adds a flush input that emits a partial, zero-padded word.
module valid_packer #(
  parameter int DW_DATA = 8,
  parameter int N_PACK  = 4,
  parameter int DEPTH   = 4,
  parameter int W_LANE  = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DW_DATA-1:0]                in_data,
`ifdef PACKER_FLUSH_EN
  input  logic                              flush,
`endif
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DW_DATA*N_PACK-1:0]         out_data,
  output logic [W_LANE-1:0]                 out_lanes,
  output logic [W_LANE+$clog2(DEPTH)-1:0]   level,
  output logic                              overflow
);

  localparam int W_WORD  = DW_DATA * N_PACK;
  localparam int W_PTR   = $clog2(DEPTH);
  localparam int W_LEVEL = W_LANE + W_PTR;
  localparam logic [W_LANE-1:0]  LAST_LANE  = W_LANE'(N_PACK - 1);
  localparam logic [W_LANE-1:0]  FULL_LANES = W_LANE'(N_PACK);
  localparam logic [W_LEVEL-1:0] LEVEL_FULL = W_LEVEL'(DEPTH);

  logic [W_LANE-1:0]  lane_cnt_reg, lane_cnt_next;
  logic [W_WORD-1:0]  asm_reg, asm_next;
  logic [W_PTR-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [W_PTR-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [W_LEVEL-1:0] level_reg, level_next;
  logic               overflow_reg, overflow_next;

  logic [W_WORD-1:0]  assembled_word;
  logic               word_done;
  logic               flush_push;
  logic               push_req;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;

  logic [W_WORD-1:0]  mem_data [DEPTH];

  // Current assembly plus the beat arriving on this edge, placed in its lane.
  genvar gi;
  generate
    for (gi = 0; gi < N_PACK; gi++) begin : g_lane
      assign assembled_word[gi*DW_DATA +: DW_DATA] =
        (in_valid && (lane_cnt_reg == W_LANE'(gi))) ? in_data
                                                    : asm_reg[gi*DW_DATA +: DW_DATA];
    end
  endgenerate

  assign word_done = in_valid && (lane_cnt_reg == LAST_LANE);

`ifdef PACKER_FLUSH_EN
  logic [W_LANE-1:0] push_lanes;
  logic [W_LANE-1:0] mem_lanes [DEPTH];

  assign flush_push = flush && ((lane_cnt_reg != '0) || in_valid);
  assign push_lanes = word_done ? FULL_LANES : (lane_cnt_reg + W_LANE'(in_valid));
`else
  assign flush_push = 1'b0;
`endif

  assign push_req = word_done || flush_push;
  assign pop      = out_valid && out_ready;
  assign full     = (level_reg == LEVEL_FULL);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    lane_cnt_next = lane_cnt_reg;
    asm_next      = asm_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;

    if (push_req) begin
      lane_cnt_next = '0;
      asm_next      = '0;
    end else if (in_valid) begin
      lane_cnt_next = lane_cnt_reg + W_LANE'(1);
      asm_next      = assembled_word;
    end

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + W_PTR'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + W_PTR'(1);
    end

    case ({push_ok, pop})
      2'b10:   level_next = level_reg + W_LEVEL'(1);
      2'b01:   level_next = level_reg - W_LEVEL'(1);
      default: level_next = level_reg;
    endcase

    if (drop) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt_reg <= '0;
      asm_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      lane_cnt_reg <= lane_cnt_next;
      asm_reg      <= asm_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_data[wr_ptr_reg] <= assembled_word;
`ifdef PACKER_FLUSH_EN
      mem_lanes[wr_ptr_reg] <= push_lanes;
`endif
    end
  end

  assign out_valid = (level_reg != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr_reg] : '0;
`ifdef PACKER_FLUSH_EN
  assign out_lanes = out_valid ? mem_lanes[rd_ptr_reg] : '0;
`else
  assign out_lanes = out_valid ? FULL_LANES : '0;
`endif
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule
